// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor control path: opcodes, sequencer
// states and fault codes. Also imported by the per-instruction control decoder.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_SW    = 4'b1111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_J     = 4'b0010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_t;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_next_pc.sv
// Combinational next-PC candidates for the sequencer: sequential, beq and j.
// All arithmetic wraps modulo 256.
module seq_next_pc (
  input  logic [7:0] pc,
  input  logic [7:0] ir_lo,
  input  logic       zero,
  output logic [7:0] pc_inc,
  output logic [7:0] pc_branch,
  output logic [7:0] pc_jump
);

  logic [7:0] br_off;

  // imm6 is sign-extended so a negative offset wraps below the current pc.
  assign br_off    = {{2{ir_lo[5]}}, ir_lo[5:0]};
  assign pc_inc    = pc + 8'd1;
  assign pc_branch = zero ? (pc_inc + br_off) : pc_inc;
  assign pc_jump   = ir_lo;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer owning pc and ir.
// Define SEQ_PERF_CNT_EN to add the retired/cycles performance counters.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] PC_RESET    = 8'h00,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] ir,
  output logic        exec_en,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  input  logic        zero,
  output logic [7:0]  pc,
  output logic        busy,
  output logic [1:0]  fault,
  output logic        halted,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0] retired,
  output logic [15:0] cycles,
`endif
  output seq_state_t  dbg_state
);

  // Handshake: a req is held high until the cycle its ack is seen; that cycle
  // completes the transfer and req drops on the next. An ack with no req is ignored.

  localparam logic [15:0] TO_LAST = (ACK_TIMEOUT == 0) ? 16'd0 : 16'(ACK_TIMEOUT - 1);

  seq_state_t  state;
  logic [15:0] tcnt;
  logic [3:0]  op;
  logic [7:0]  pc_inc, pc_branch, pc_jump;
  logic        timed_out;

  assign op        = ir[15:12];
  assign imem_addr = pc;
  assign dbg_state = state;
  assign timed_out = (ACK_TIMEOUT != 0) && (tcnt == TO_LAST);

  seq_next_pc u_next_pc (
    .pc        (pc),
    .ir_lo     (ir[7:0]),
    .zero      (zero),
    .pc_inc    (pc_inc),
    .pc_branch (pc_branch),
    .pc_jump   (pc_jump)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      pc       <= PC_RESET;
      ir       <= 16'h0000;
      fault    <= FAULT_NONE;
      tcnt     <= 16'd0;
      imem_req <= 1'b0;
      exec_en  <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_we    <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      exec_en <= 1'b0;
      rf_we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            tcnt     <= 16'd0;
            state    <= ST_DECODE;
          end else if (timed_out) begin
            imem_req <= 1'b0;
            tcnt     <= 16'd0;
            fault    <= FAULT_TIMEOUT;
            state    <= ST_HALT;
            busy     <= 1'b0;
            halted   <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        ST_DECODE: begin
          if (!op_legal(op)) begin
            fault  <= FAULT_ILLEGAL;
            state  <= ST_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            exec_en <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op == OP_LW || op == OP_SW) begin
            dmem_req <= 1'b1;
            dmem_we  <= (op == OP_SW);
            state    <= ST_MEM;
          end else if (op == OP_BEQ || op == OP_J) begin
            pc       <= (op == OP_BEQ) ? pc_branch : pc_jump;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end else begin
            rf_we <= 1'b1;
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            tcnt     <= 16'd0;
            if (op == OP_SW) begin
              pc       <= pc_inc;
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end else begin
              rf_we <= 1'b1;
              state <= ST_WB;
            end
          end else if (timed_out) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            tcnt     <= 16'd0;
            fault    <= FAULT_TIMEOUT;
            state    <= ST_HALT;
            busy     <= 1'b0;
            halted   <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        ST_WB: begin
          pc       <= pc_inc;
          imem_req <= 1'b1;
          state    <= ST_FETCH;
        end
        ST_HALT: begin
          if (start) begin
            fault    <= FAULT_NONE;
            halted   <= 1'b0;
            busy     <= 1'b1;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic retire;

  assign retire = (state == ST_WB) ||
                  (state == ST_MEM  && dmem_ack && op == OP_SW) ||
                  (state == ST_EXEC && (op == OP_BEQ || op == OP_J));

  // Both counters saturate and survive start; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired <= 16'd0;
      cycles  <= 16'd0;
    end else begin
      if (retire && retired != 16'hFFFF) retired <= retired + 16'd1;
      if (busy && cycles != 16'hFFFF)    cycles  <= cycles + 16'd1;
    end
  end
`endif

endmodule
